// File: rtl/if_id_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction-memory port, IF/ID register contents out.
interface if_id_stage_if #(
    parameter int CNT_W = 16
);
    logic             pcwrite;
    logic             if_id_write;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             jump;
    logic [31:0]      jump_target;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      if_id_instr;
    logic [31:0]      if_id_pc4;
    logic             if_id_valid;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output pcwrite, if_id_write, branch_taken, branch_target, jump, jump_target, imem_rdata,
        input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, stall_cnt
    );

    modport slave (
        input  pcwrite, if_id_write, branch_taken, branch_target, jump, jump_target, imem_rdata,
        output imem_addr, if_id_instr, if_id_pc4, if_id_valid, stall_cnt
    );
endinterface

// File: rtl/if_id_stage.sv
// PC register plus IF/ID pipeline register; imem read is combinational, so an instruction lands in IF/ID one cycle after its PC.
// Stalls hold PC and IF/ID through pcwrite/if_id_write; branch/jump redirects override stalls and flush IF/ID.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    if_id_stage_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             redirect;
    logic [31:0]      redirect_target;
    logic             stall;
    logic [31:0]      instr_q;
    logic [31:0]      pc4_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    // The branch sits in EX and is older than the jump in ID, so it wins.
    always_comb begin
        redirect             = bus.branch_taken | bus.jump;
        redirect_target      = bus.branch_taken ? bus.branch_target : bus.jump_target;
        redirect_target[1:0] = 2'b00;
    end

    assign pc_plus4 = pc + 32'd4;
    assign stall    = ~bus.pcwrite & ~redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_target;
        end else if (bus.pcwrite) begin
            pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else if (bus.if_id_write) begin
            instr_q <= bus.imem_rdata;
            pc4_q   <= pc_plus4;
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_valid = valid_q;
    assign bus.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: a per-cycle reference model feeds a scoreboard queue, plus directed checks on the key scenarios.
module tb_if_id_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;

    if_id_stage_if #(.CNT_W(16)) bus ();
    if_id_stage_if #(.CNT_W(16)) bus2 ();

    // Instruction memory returns a word equal to its address.
    assign bus.imem_rdata  = bus.imem_addr;
    assign bus2.imem_rdata = bus2.imem_addr;

    if_id_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    if_id_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000), .CNT_W(16)) dut_wrap (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t model;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, written from the stage's rules.
    function automatic exp_t next_state(input exp_t cur, input logic r, input logic pw, input logic iw,
                                        input logic bt, input logic [31:0] bt_t,
                                        input logic j, input logic [31:0] j_t);
        exp_t        n;
        logic [31:0] tgt;
        n = cur;
        if (r) begin
            n.pc    = 32'h0000_0000;
            n.instr = 32'h0000_0000;
            n.pc4   = 32'h0;
            n.valid = 1'b0;
            n.cnt   = 16'h0;
        end else if (bt || j) begin
            tgt     = bt ? bt_t : j_t;
            n.pc    = {tgt[31:2], 2'b00};
            n.instr = 32'h0000_0000;
            n.pc4   = 32'h0;
            n.valid = 1'b0;
        end else begin
            if (pw) n.pc = cur.pc + 32'd4;
            if (iw) begin
                n.instr = cur.pc;
                n.pc4   = cur.pc + 32'd4;
                n.valid = 1'b1;
            end
            if (!pw && cur.cnt != 16'hFFFF) n.cnt = cur.cnt + 16'd1;
        end
        return n;
    endfunction

    task automatic sb_compare();
        exp_t e;
        check_val("sb_depth", 32'(sb_q.size()), 32'd1);
        e = sb_q.pop_front();
        check_val("imem_addr", bus.imem_addr, e.pc);
        check_val("if_id_instr", bus.if_id_instr, e.instr);
        check_val("if_id_pc4", bus.if_id_pc4, e.pc4);
        check_val("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
        check_val("stall_cnt", {16'd0, bus.stall_cnt}, {16'd0, e.cnt});
    endtask

    task automatic step(input logic r, input logic pw, input logic iw,
                        input logic bt, input logic [31:0] bt_t,
                        input logic j, input logic [31:0] j_t, input bit do_sb);
        @(negedge clk);
        rst               = r;
        bus.pcwrite       = pw;
        bus.if_id_write   = iw;
        bus.branch_taken  = bt;
        bus.branch_target = bt_t;
        bus.jump          = j;
        bus.jump_target   = j_t;
        model = next_state(model, r, pw, iw, bt, bt_t, j, j_t);
        if (do_sb) sb_q.push_back(model);
        @(posedge clk);
        #1;
        if (do_sb) sb_compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        bus.pcwrite = 1'b1; bus.if_id_write = 1'b1;
        bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
        bus.jump = 1'b0; bus.jump_target = 32'h0;
        bus2.pcwrite = 1'b1; bus2.if_id_write = 1'b1;
        bus2.branch_taken = 1'b0; bus2.branch_target = 32'h0;
        bus2.jump = 1'b0; bus2.jump_target = 32'h0;
        model = '0;

        // Reset state
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_val("rst_pc", bus.imem_addr, 32'h0);
        check_val("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
        check_val("rst_cnt", {16'd0, bus.stall_cnt}, 32'd0);

        // Free run: 0,4,8 then IF/ID follows one cycle behind
        run(1);
        check_val("run1_pc", bus.imem_addr, 32'h4);
        check_val("run1_instr", bus.if_id_instr, 32'h0);
        check_val("run1_pc4", bus.if_id_pc4, 32'h4);
        check_val("run1_valid", {31'd0, bus.if_id_valid}, 32'd1);
        run(1);
        check_val("run2_pc", bus.imem_addr, 32'h8);
        check_val("run2_instr", bus.if_id_instr, 32'h4);

        // One-cycle load-use stall at pc=8
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_val("stall_pc", bus.imem_addr, 32'h8);
        check_val("stall_instr", bus.if_id_instr, 32'h4);
        check_val("stall_pc4", bus.if_id_pc4, 32'h8);
        check_val("stall_cnt1", {16'd0, bus.stall_cnt}, 32'd1);
        run(1);
        check_val("resume_pc", bus.imem_addr, 32'hC);
        check_val("resume_instr", bus.if_id_instr, 32'h8);
        run(1);
        check_val("resume2_instr", bus.if_id_instr, 32'hC);
        check_val("resume2_pc4", bus.if_id_pc4, 32'h10);

        // Branch during a stall: redirect wins, no count
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0, 1'b1);
        check_val("br_pc", bus.imem_addr, 32'h100);
        check_val("br_instr", bus.if_id_instr, 32'h0);
        check_val("br_pc4", bus.if_id_pc4, 32'h0);
        check_val("br_valid", {31'd0, bus.if_id_valid}, 32'd0);
        check_val("br_cnt", {16'd0, bus.stall_cnt}, 32'd1);
        run(2);

        // Branch and jump together: branch wins
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
        check_val("both_pc", bus.imem_addr, 32'h40);
        check_val("both_valid", {31'd0, bus.if_id_valid}, 32'd0);

        // Jump alone with misaligned target
        run(1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0207, 1'b1);
        check_val("jmp_pc", bus.imem_addr, 32'h204);
        check_val("jmp_valid", {31'd0, bus.if_id_valid}, 32'd0);

        // Enables disagree: each register follows its own enable
        run(1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        run(1);

        // Randomised traffic through the scoreboard
        for (int i = 0; i < 400; i++) begin
            logic pw, iw, bt, j, r;
            pw = ($urandom_range(0, 3) != 0);
            iw = ($urandom_range(0, 9) == 0) ? ~pw : pw;
            bt = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 49) == 0);
            step(r, pw, iw, bt, $urandom, j, $urandom, 1'b1);
        end

        // Long stall: counter saturates at all-ones
        for (int i = 0; i < 65540; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, (i >= 65530));
        check_val("sat_cnt", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);
        run(1);
        check_val("sat_hold", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);

        // Reset during a stall with a branch asserted
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
        check_val("rstmid_pc", bus.imem_addr, 32'h0);
        check_val("rstmid_valid", {31'd0, bus.if_id_valid}, 32'd0);
        check_val("rstmid_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        run(2);

        // PC wrap from 32'hFFFF_FFFC
        @(negedge clk);
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        check_val("wrap_rst_pc", bus2.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        rst2 = 1'b0;
        @(posedge clk);
        #1;
        check_val("wrap_pc", bus2.imem_addr, 32'h0);
        check_val("wrap_instr", bus2.if_id_instr, 32'hFFFF_FFFC);
        check_val("wrap_pc4", bus2.if_id_pc4, 32'h0);
        check_val("wrap_valid", {31'd0, bus2.if_id_valid}, 32'd1);

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch stage plus IF/ID pipeline register for the 5-stage 32-bit MIPS pipeline.
- Holds the PC and drives the instruction-memory address; the instruction memory is read combinationally.
- Registers the fetched instruction and its PC+4 into IF/ID.
- Consumes pcwrite/if_id_write from the hazard detection unit, a branch redirect resolved in EX, and a jump redirect resolved in ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on flush or reset (sll $0,$0,0).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- pcwrite  input  1  1 = PC may advance; 0 = hold PC (load-use stall)
- if_id_write  input  1  1 = IF/ID may load; 0 = hold IF/ID
- branch_taken  input  1  taken branch resolved in EX; redirect and flush
- branch_target  input  32  branch destination
- jump  input  1  jump decoded in ID; redirect and flush
- jump_target  input  32  jump destination
- imem_addr  output  32  current PC to instruction memory
- imem_rdata  input  32  instruction at imem_addr, same cycle
- if_id_instr  output  32  registered instruction
- if_id_pc4  output  32  registered PC+4 of that instruction
- if_id_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble
- stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (sync, at rising edge with rst=1):
  - pc = RESET_PC.
  - if_id_instr = NOP_INSTR, if_id_pc4 = 0, if_id_valid = 0.
  - stall_cnt = 0.
  - rst overrides all other inputs in the same cycle, including a reset asserted mid-stall or mid-redirect.
- imem_addr = pc, combinational from the PC register. There is one cycle of latency from PC update to the IF/ID capture of that instruction.
- pc_plus4 = pc + 4, computed modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- redirect = branch_taken | jump.
- Redirect target:
  - branch_taken has priority over jump (the branch is the older instruction).
  - Bits [1:0] of the selected target are forced to 0.
- Next PC priority, highest first:
  - rst
  - redirect: pc <= target. This overrides pcwrite=0, because the stalled instruction is younger than the redirecting one.
  - pcwrite=0: hold
  - otherwise: pc <= pc_plus4
- IF/ID update priority, highest first:
  - rst
  - redirect (flush): if_id_instr <= NOP_INSTR, if_id_valid <= 0, if_id_pc4 <= 0. This overrides if_id_write=0.
  - if_id_write=0: hold all three registers
  - otherwise: if_id_instr <= imem_rdata, if_id_pc4 <= pc_plus4, if_id_valid <= 1
- Flush scope: a flush covers only IF/ID. ID/EX squash on branch_taken is not this block's responsibility.
- pcwrite and if_id_write are normally equal. If they differ, each register follows its own enable independently; no error is flagged.
- stall_cnt:
  - Increments when pcwrite=0 and redirect=0.
  - Saturates at all-ones and never wraps.
  - Clears only on rst.
- There is no state machine beyond the PC, IF/ID and counter registers. The block is fully synchronous, with no latches or combinational loops.

Test Plan:
- Reset then free-run, with imem returning a word equal to its address: imem_addr sequences 0,4,8,C. One cycle after each address, if_id_instr = that address, if_id_pc4 = address+4, if_id_valid=1.
- Load-use stall: pcwrite=if_id_write=0 for exactly 1 cycle while pc=8. PC holds at 8 for one extra cycle, IF/ID holds instr 4 / pc4 8, and stall_cnt goes 0→1. Flow then resumes with 8 then C.
- Branch during stall: pcwrite=0 together with branch_taken=1 and target 32'h0000_0103. pc=32'h100 next cycle, IF/ID = NOP_INSTR with valid=0 and pc4=0, and stall_cnt does not increment.
- Branch and jump in the same cycle: branch_target=32'h40, jump_target=32'h80. pc=32'h40 and IF/ID is flushed.
- Boundary cases:
  - RESET_PC=32'hFFFF_FFFC: PC wraps to 0 after one cycle.
  - Stall held for 65540 cycles with CNT_W=16: stall_cnt stays at 16'hFFFF.
- Reset mid-stall with branch asserted: rst=1 alongside pcwrite=0 and branch_taken=1. Next cycle pc=RESET_PC, valid=0, stall_cnt=0.
